// File: rtl/csr_req_initiator.sv
// csr_req_initiator: single-outstanding CSR request initiator with per-handshake timeout
module csr_req_initiator #(
  parameter int RegAddrWidth  = 3,
  parameter int RegDataWidth  = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [RegAddrWidth-1:0] cmd_addr_i,
  input  logic [RegDataWidth-1:0] cmd_wr_data_i,
  input  logic                    cmd_wr_en_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [RegDataWidth-1:0] res_rd_data_o,
  output logic                    res_timeout_o,
  output logic [RegAddrWidth-1:0] csr_addr_o,
  output logic [RegDataWidth-1:0] csr_wr_data_o,
  output logic                    csr_wr_en_o,
  output logic                    csr_req_valid_o,
  input  logic                    csr_req_ready_i,
  input  logic [RegDataWidth-1:0] csr_rd_data_i,
  input  logic                    csr_rsp_valid_i,
  output logic                    csr_rsp_ready_o,
  output logic [15:0]             txn_count_o
);
  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;
  localparam logic [15:0] TLast = 16'(TimeoutCycles - 1);
  state_t state, state_n;
  logic [RegAddrWidth-1:0] addr_q;
  logic [RegDataWidth-1:0] wdata_q;
  logic wen_q;
  logic [15:0] tcnt;
  logic req_hs, rsp_hs, tmo_hit, waiting;
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    waiting = state == REQ || state == RSP;
    req_hs = state == REQ && csr_req_ready_i;
    rsp_hs = state == RSP && csr_rsp_valid_i;
    // a handshake on the last counted cycle beats the timeout
    tmo_hit = waiting && tcnt == TLast && !req_hs && !rsp_hs;
    cmd_ready_o = state == IDLE && !rst_i;
    csr_req_valid_o = state == REQ;
    csr_rsp_ready_o = state == RSP;
    res_valid_o = state == DONE;
    csr_addr_o = csr_req_valid_o ? addr_q : '0;
    csr_wr_data_o = csr_req_valid_o ? wdata_q : '0;
    csr_wr_en_o = csr_req_valid_o && wen_q;
    state_n = state;
    case (state)
      IDLE: state_n = cmd_valid_i ? REQ : IDLE;
      REQ:  state_n = req_hs ? RSP : tmo_hit ? DONE : REQ;
      RSP:  state_n = (rsp_hs || tmo_hit) ? DONE : RSP;
      DONE: state_n = res_ready_i ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      wdata_q <= '0;
      wen_q <= 1'b0;
      tcnt <= '0;
      res_rd_data_o <= '0;
      res_timeout_o <= 1'b0;
      txn_count_o <= '0;
    end else begin
      if (cmd_ready_o && cmd_valid_i) begin
        addr_q <= cmd_addr_i;
        wdata_q <= cmd_wr_data_i;
        wen_q <= cmd_wr_en_i;
        tcnt <= '0;
      end else if (req_hs || rsp_hs) tcnt <= '0;
      else if (waiting) tcnt <= tcnt + 16'd1;
      if (rsp_hs) begin
        res_rd_data_o <= csr_rd_data_i;
        res_timeout_o <= 1'b0;
        txn_count_o <= txn_count_o + 16'd1;
      end else if (tmo_hit) begin
        res_rd_data_o <= '0;
        res_timeout_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_csr_req_initiator.sv
// tb_csr_req_initiator: directed checks of csr_req_initiator with a register-file responder
module tb_csr_req_initiator;
  logic clk = 0;
  logic rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_wr_en = 0;
  logic [2:0] cmd_addr = 0;
  logic [31:0] cmd_wr_data = 0;
  logic res_valid, res_ready = 0, res_timeout;
  logic [31:0] res_rd_data;
  logic [2:0] csr_addr;
  logic [31:0] csr_wr_data, csr_rd_data = 0;
  logic csr_wr_en, csr_req_valid, csr_req_ready = 1, csr_rsp_valid = 0, csr_rsp_ready;
  logic [15:0] txn_count;
  logic cmd_valid4 = 0, cmd_ready4, res_valid4, res_ready4 = 0, res_timeout4;
  logic [31:0] res_rd_data4, csr_wr_data4, csr_rd_data4 = 0;
  logic [2:0] csr_addr4;
  logic csr_wr_en4, csr_req_valid4, csr_req_ready4 = 0, csr_rsp_valid4 = 0, csr_rsp_ready4;
  logic [15:0] txn_count4;
  logic [31:0] regs [8] = '{default: 32'h0};
  logic pend = 0, rsp_en = 1;
  logic [31:0] pend_data = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  csr_req_initiator dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_wr_data_i(cmd_wr_data), .cmd_wr_en_i(cmd_wr_en),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_rd_data_o(res_rd_data),
    .res_timeout_o(res_timeout), .csr_addr_o(csr_addr), .csr_wr_data_o(csr_wr_data),
    .csr_wr_en_o(csr_wr_en), .csr_req_valid_o(csr_req_valid), .csr_req_ready_i(csr_req_ready),
    .csr_rd_data_i(csr_rd_data), .csr_rsp_valid_i(csr_rsp_valid), .csr_rsp_ready_o(csr_rsp_ready),
    .txn_count_o(txn_count)
  );
  csr_req_initiator #(.TimeoutCycles(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid4), .cmd_ready_o(cmd_ready4),
    .cmd_addr_i(cmd_addr), .cmd_wr_data_i(cmd_wr_data), .cmd_wr_en_i(cmd_wr_en),
    .res_valid_o(res_valid4), .res_ready_i(res_ready4), .res_rd_data_o(res_rd_data4),
    .res_timeout_o(res_timeout4), .csr_addr_o(csr_addr4), .csr_wr_data_o(csr_wr_data4),
    .csr_wr_en_o(csr_wr_en4), .csr_req_valid_o(csr_req_valid4), .csr_req_ready_i(csr_req_ready4),
    .csr_rd_data_i(csr_rd_data4), .csr_rsp_valid_i(csr_rsp_valid4), .csr_rsp_ready_o(csr_rsp_ready4),
    .txn_count_o(txn_count4)
  );
  // responder: returns the prior register value one cycle after accepting a request, then writes
  always @(negedge clk) begin
    csr_rsp_valid = pend && rsp_en;
    csr_rd_data = pend_data;
    pend = csr_req_valid && csr_req_ready;
    if (pend) begin
      pend_data = regs[csr_addr];
      if (csr_wr_en) regs[csr_addr] = csr_wr_data;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_txn", txn_count, 0);
    chk("rst_req_valid", csr_req_valid, 0);
    rst = 0;
    tick();
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_res_valid", res_valid, 0);
    chk("idle_addr", csr_addr, 0);
    cmd_valid = 1; cmd_addr = 2; cmd_wr_data = 32'hDEADBEEF; cmd_wr_en = 1;
    tick();
    cmd_valid = 0;
    chk("wr_c1_req_valid", csr_req_valid, 1);
    chk("wr_c1_addr", csr_addr, 2);
    chk("wr_c1_data", csr_wr_data, 32'hDEADBEEF);
    chk("wr_c1_wen", csr_wr_en, 1);
    chk("wr_c1_cmd_ready", cmd_ready, 0);
    tick();
    chk("wr_c2_rsp_ready", csr_rsp_ready, 1);
    chk("wr_c2_req_valid", csr_req_valid, 0);
    chk("wr_c2_addr_zero", csr_addr, 0);
    tick();
    chk("wr_c3_res_valid", res_valid, 1);
    chk("wr_c3_rd_data", res_rd_data, 0);
    chk("wr_c3_timeout", res_timeout, 0);
    chk("wr_c3_txn", txn_count, 1);
    chk("wr_done_cmd_ready", cmd_ready, 0);
    res_ready = 1;
    tick();
    res_ready = 0;
    chk("wr_back_idle", cmd_ready, 1);
    chk("wr_back_res_valid", res_valid, 0);
    cmd_valid = 1; cmd_addr = 2; cmd_wr_data = 32'h0; cmd_wr_en = 0;
    tick();
    cmd_valid = 0;
    chk("rd_c1_wen", csr_wr_en, 0);
    tick();
    tick();
    chk("rd_res_valid", res_valid, 1);
    chk("rd_data", res_rd_data, 32'hDEADBEEF);
    chk("rd_timeout", res_timeout, 0);
    chk("rd_txn", txn_count, 2);
    res_ready = 1;
    tick();
    res_ready = 0;
    csr_req_ready = 0;
    cmd_valid = 1; cmd_addr = 2; cmd_wr_data = 32'h12345678; cmd_wr_en = 0;
    tick();
    cmd_valid = 0;
    cmd_addr = 5; cmd_wr_data = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_valid", csr_req_valid, 1);
      chk("bp_req_fields", {csr_addr, csr_wr_data, csr_wr_en}, {3'd2, 32'h12345678, 1'b0});
      tick();
    end
    chk("bp_still_req", csr_req_valid, 1);
    csr_req_ready = 1;
    tick();
    chk("bp_rsp_state", csr_rsp_ready, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_rd_data, 32'hDEADBEEF);
      chk("bp_res_txn", txn_count, 3);
      tick();
    end
    res_ready = 1;
    tick();
    res_ready = 0;
    chk("bp_one_result", res_valid, 0);
    tick();
    chk("bp_no_second", res_valid, 0);
    chk("bp_txn_final", txn_count, 3);
    rsp_en = 0;
    cmd_valid = 1; cmd_addr = 2; cmd_wr_en = 0;
    tick();
    cmd_valid = 0;
    tick();
    chk("rr_in_rsp", csr_rsp_ready, 1);
    rst = 1;
    tick();
    chk("rr_cmd_ready", cmd_ready, 0);
    chk("rr_outputs", {res_valid, csr_req_valid, csr_rsp_ready, res_timeout}, 0);
    chk("rr_txn", txn_count, 0);
    chk("rr_rd_data", res_rd_data, 0);
    rst = 0;
    rsp_en = 1;
    tick();
    chk("rr_idle", cmd_ready, 1);
    chk("rr_no_result", res_valid, 0);
    csr_req_ready4 = 1;
    cmd_valid4 = 1; cmd_addr = 1; cmd_wr_en = 0;
    tick();
    cmd_valid4 = 0;
    tick();
    chk("race_rsp_state", csr_rsp_ready4, 1);
    tick();
    tick();
    tick();
    chk("race_still_rsp", csr_rsp_ready4, 1);
    csr_rsp_valid4 = 1; csr_rd_data4 = 32'hCAFEF00D;
    tick();
    csr_rsp_valid4 = 0;
    chk("race_res_valid", res_valid4, 1);
    chk("race_data", res_rd_data4, 32'hCAFEF00D);
    chk("race_timeout", res_timeout4, 0);
    chk("race_txn", txn_count4, 1);
    res_ready4 = 1;
    tick();
    res_ready4 = 0;
    csr_req_ready4 = 0;
    cmd_valid4 = 1; cmd_addr = 3;
    tick();
    cmd_valid4 = 0;
    tick();
    tick();
    tick();
    chk("to_still_req", csr_req_valid4, 1);
    tick();
    chk("to_res_valid", res_valid4, 1);
    chk("to_flag", res_timeout4, 1);
    chk("to_data", res_rd_data4, 0);
    chk("to_txn", txn_count4, 1);
    csr_rsp_valid4 = 1; csr_rd_data4 = 32'h0000AAAA;
    res_ready4 = 1;
    tick();
    res_ready4 = 0;
    chk("to_idle", cmd_ready4, 1);
    tick();
    csr_rsp_valid4 = 0;
    chk("late_rsp_idle", cmd_ready4, 1);
    chk("late_rsp_no_res", res_valid4, 0);
    chk("late_rsp_data", res_rd_data4, 0);
    chk("late_rsp_txn", txn_count4, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
